// File: rtl/sample_streamer.sv
// Streams entropy samples to a UART sender as hex words with CR/LF line breaks.
// Optional macro STREAMER_SEPARATOR_EN inserts a 0x20 byte between words on a line.
module sample_streamer #(
  parameter int WORDS_PER_LINE = 8,
  parameter int TOTAL_WORDS    = 1024
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  input  logic [31:0] SAMPLE,
  input  logic        SAMPLE_VALID,
  input  logic        READY,
  output logic [31:0] DATA,
  output logic        WE,
  output logic        MODE,
  output logic        BUSY,
  output logic        DONE,
  output logic        OVERFLOW
);

`ifdef STREAMER_SEPARATOR_EN
  typedef enum logic [2:0] {
    IDLE, WORD, SEP, CR, LF
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE, WORD, CR, LF
  } state_t;
`endif

  localparam logic [7:0]  WPL = 8'(WORDS_PER_LINE);
  localparam logic [15:0] TOT = 16'(TOTAL_WORDS);

  state_t      state_q, state_d;
  logic [15:0] wcnt_q, wcnt_d;
  logic [7:0]  col_q, col_d;
  logic        ovf_q, ovf_d;

  logic [31:0] mem_q [4];
  logic [1:0]  wr_q, rd_q;
  logic [2:0]  cnt_q, cnt_d;

  logic        busy_w;
  logic        pop;
  logic        push_req;
  logic        accept;
  logic        fifo_clr;
  logic        line_end;
  logic        dump_end;
  logic        we_c;
  logic        mode_c;
  logic        done_c;
  logic [31:0] data_c;

  assign busy_w   = (state_q != IDLE);
  assign push_req = busy_w && SAMPLE_VALID;
  assign accept   = push_req && (!cnt_q[2] || pop);
  assign line_end = ((col_q + 8'd1) == WPL);
  assign dump_end = ((wcnt_q + 16'd1) == TOT);

  always_comb begin
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    col_d    = col_q;
    ovf_d    = ovf_q;
    fifo_clr = 1'b0;
    pop      = 1'b0;
    we_c     = 1'b0;
    mode_c   = 1'b0;
    done_c   = 1'b0;
    data_c   = 32'h0;
    unique case (state_q)
      IDLE: begin
        if (START) begin
          state_d  = WORD;
          wcnt_d   = 16'h0;
          col_d    = 8'h0;
          ovf_d    = 1'b0;
          fifo_clr = 1'b1;
        end
      end
      WORD: begin
        if (cnt_q != 3'd0 && READY) begin
          we_c   = 1'b1;
          data_c = mem_q[rd_q];
          pop    = 1'b1;
          wcnt_d = wcnt_q + 16'd1;
          col_d  = col_q + 8'd1;
          if (line_end || dump_end) begin
            state_d = CR;
          end else begin
`ifdef STREAMER_SEPARATOR_EN
            state_d = SEP;
`else
            state_d = WORD;
`endif
          end
        end
      end
`ifdef STREAMER_SEPARATOR_EN
      SEP: begin
        if (READY) begin
          we_c    = 1'b1;
          mode_c  = 1'b1;
          data_c  = 32'h20;
          state_d = WORD;
        end
      end
`endif
      CR: begin
        if (READY) begin
          we_c    = 1'b1;
          mode_c  = 1'b1;
          data_c  = 32'h0D;
          state_d = LF;
        end
      end
      LF: begin
        if (READY) begin
          we_c   = 1'b1;
          mode_c = 1'b1;
          data_c = 32'h0A;
          col_d  = 8'h0;
          if (wcnt_q == TOT) begin
            state_d = IDLE;
            done_c  = 1'b1;
          end else begin
            state_d = WORD;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Drops only happen while busy, so this never fights the START clear.
    if (push_req && !accept) begin
      ovf_d = 1'b1;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    unique case ({accept, pop})
      2'b10:   cnt_d = cnt_q + 3'd1;
      2'b01:   cnt_d = cnt_q - 3'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      wcnt_q  <= 16'h0;
      col_q   <= 8'h0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      col_q   <= col_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST || fifo_clr) begin
      wr_q  <= 2'd0;
      rd_q  <= 2'd0;
      cnt_q <= 3'd0;
    end else begin
      if (accept) begin
        wr_q <= wr_q + 2'd1;
      end
      if (pop) begin
        rd_q <= rd_q + 2'd1;
      end
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST && !fifo_clr && accept) begin
      mem_q[wr_q] <= SAMPLE;
    end
  end

  // Reset masks outputs immediately, before the state register catches up.
  assign WE       = we_c && !RST;
  assign MODE     = mode_c && !RST;
  assign DATA     = RST ? 32'h0 : data_c;
  assign DONE     = done_c && !RST;
  assign BUSY     = busy_w && !RST;
  assign OVERFLOW = ovf_q && !RST;

endmodule

// File: tb/tb_sample_streamer.sv
// Bench for sample_streamer: two instances checked each cycle against a
// token-stream model, plus literal write sequences for the directed cases.
module tb_sample_streamer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] sample;
  logic        svalid;
  logic        ready;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : u
    localparam int WPL = 2;
    localparam int TOT = (g == 0) ? 4 : 3;
    logic [31:0] data;
    logic        we, mode, busy, done, ovf;

    sample_streamer #(
      .WORDS_PER_LINE(WPL),
      .TOTAL_WORDS(TOT)
    ) dut (
      .CLK(clk), .RST(rst), .START(start),
      .SAMPLE(sample), .SAMPLE_VALID(svalid),
      .READY(ready), .DATA(data), .WE(we),
      .MODE(mode), .BUSY(busy), .DONE(done),
      .OVERFLOW(ovf)
    );

    int          tok[$];
    logic [31:0] sq[$];
    bit          mb = 1'b0;
    bit          mo = 1'b0;

    always @(negedge clk) begin
      bit wr;
      bit isw;
      bit dn;
      logic [31:0] ed;
      wr  = 1'b0;
      isw = 1'b0;
      dn  = 1'b0;
      ed  = 32'h0;
      if (!rst && mb && tok.size() > 0) begin
        isw = (tok[0] < 0);
        wr  = ready && (!isw || sq.size() > 0);
        if (wr) ed = isw ? sq[0] : 32'(tok[0]);
        dn = wr && (tok.size() == 1);
      end
      chk($sformatf("u%0d.WE", g), 64'(we), 64'(wr));
      chk($sformatf("u%0d.DATA", g), 64'(data), 64'(ed));
      chk($sformatf("u%0d.MODE", g), 64'(mode), 64'(wr && !isw));
      chk($sformatf("u%0d.BUSY", g), 64'(busy), 64'(mb && !rst));
      chk($sformatf("u%0d.DONE", g), 64'(done), 64'(dn));
      chk($sformatf("u%0d.OVF", g), 64'(ovf), 64'(mo && !rst));
      if (rst) begin
        mb = 1'b0;
        mo = 1'b0;
        tok.delete();
        sq.delete();
      end else if (!mb) begin
        if (start) begin
          mb = 1'b1;
          mo = 1'b0;
          sq.delete();
          tok.delete();
          for (int i = 0; i < TOT; i++) begin
            tok.push_back(-1);
            if ((i + 1) % WPL == 0 || i + 1 == TOT) begin
              tok.push_back(13);
              tok.push_back(10);
            end else begin
`ifdef STREAMER_SEPARATOR_EN
              tok.push_back(32);
`endif
            end
          end
        end
      end else begin
        if (wr && isw) void'(sq.pop_front());
        if (svalid) begin
          if (sq.size() < 4) sq.push_back(sample);
          else mo = 1'b1;
        end
        if (wr) begin
          void'(tok.pop_front());
          if (tok.size() == 0) mb = 1'b0;
        end
      end
    end
  end

  logic [32:0] cap0[$];
  logic [32:0] cap1[$];

  always @(negedge clk) begin
    if (u[0].we) cap0.push_back({u[0].mode, u[0].data});
    if (u[1].we) cap1.push_back({u[1].mode, u[1].data});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((u[0].busy || u[1].busy) && n < budget) begin
      tick();
      n++;
    end
    chk("idle_timeout", 64'(n < budget), 64'd1);
  endtask

  task automatic feed(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      sample = base + 32'(i);
      svalid = 1'b1;
      tick();
    end
    svalid = 1'b0;
  endtask

  task automatic chk_seq(input string nm, input logic [32:0] got[$],
                         input logic [32:0] exp[$]);
    chk({nm, ".len"}, 64'(got.size()), 64'(exp.size()));
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      chk($sformatf("%s[%0d]", nm, i), 64'(got[i]), 64'(exp[i]));
  endtask

  task automatic chk_words(input string nm, input logic [32:0] got[$],
                           input logic [31:0] exp[$]);
    int k;
    k = 0;
    foreach (got[i]) begin
      if (!got[i][32]) begin
        if (k < exp.size())
          chk($sformatf("%s.w%0d", nm, k), 64'(got[i][31:0]), 64'(exp[k]));
        k++;
      end
    end
    chk({nm, ".nwords"}, 64'(k), 64'(exp.size()));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [32:0] e0[$];
    logic [32:0] e1[$];
    logic [31:0] w[$];
    rst    = 1'b1;
    start  = 1'b0;
    svalid = 1'b0;
    ready  = 1'b0;
    sample = 32'h0;
    repeat (3) tick();
    @(negedge clk);
    chk("rst.BUSY", 64'(u[0].busy), 64'd0);
    chk("rst.WE", 64'(u[0].we), 64'd0);
    chk("rst.OVF", 64'(u[0].ovf), 64'd0);
    rst = 1'b0;
    tick();

    cap0.delete();
    cap1.delete();
    ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    feed(32'd1, 4);
    wait_idle(100);
`ifdef STREAMER_SEPARATOR_EN
    e0 = '{33'h000000001, 33'h100000020, 33'h000000002,
           33'h10000000D, 33'h10000000A, 33'h000000003,
           33'h100000020, 33'h000000004, 33'h10000000D,
           33'h10000000A};
    e1 = '{33'h000000001, 33'h100000020, 33'h000000002,
           33'h10000000D, 33'h10000000A, 33'h000000003,
           33'h10000000D, 33'h10000000A};
`else
    e0 = '{33'h000000001, 33'h000000002, 33'h10000000D,
           33'h10000000A, 33'h000000003, 33'h000000004,
           33'h10000000D, 33'h10000000A};
    e1 = '{33'h000000001, 33'h000000002, 33'h10000000D,
           33'h10000000A, 33'h000000003, 33'h10000000D,
           33'h10000000A};
`endif
    chk_seq("seq0", cap0, e0);
    chk_seq("seq1", cap1, e1);

    cap0.delete();
    cap1.delete();
    ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    feed(32'hA0, 6);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (13) tick();
    @(negedge clk);
    chk("ovf.set", 64'(u[0].ovf), 64'd1);
    ready = 1'b1;
    tick();
    wait_idle(100);
    w = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
    chk_words("ovf0", cap0, w);
    w = '{32'hA0, 32'hA1, 32'hA2};
    chk_words("ovf1", cap1, w);

    ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    feed(32'hB0, 4);
    ready  = 1'b1;
    svalid = 1'b1;
    sample = 32'hB4;
    tick();
    ready  = 1'b0;
    svalid = 1'b0;
    tick();
    @(negedge clk);
    chk("full.pop.OVF", 64'(u[0].ovf), 64'd0);
    ready = 1'b1;
    tick();
    wait_idle(100);

    ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    feed(32'hC0, 6);
    ready = 1'b1;
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk("midrst.WE", 64'(u[0].we), 64'd0);
    chk("midrst.BUSY", 64'(u[0].busy), 64'd0);
    chk("midrst.OVF", 64'(u[0].ovf), 64'd0);
    tick();
    rst = 1'b0;
    repeat (4) tick();

    cap0.delete();
    cap1.delete();
    sample = 32'hDEAD;
    svalid = 1'b1;
    tick();
    svalid = 1'b0;
    start  = 1'b1;
    tick();
    start = 1'b0;
    feed(32'h1234, 4);
    wait_idle(100);
    chk("idle.first", 64'(cap0.size() > 0 ? cap0[0] : 33'h0),
        64'h0_00001234);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
